// File: rtl/btn_debounce.sv
// btn_debounce: per-channel push-button debouncer with press/release/long-press pulses.
//
// Each raw button bit passes through a two-flop synchronizer. A four-state FSM per channel
// then accepts a level change only after DEBOUNCE_CYCLES consecutive stable samples.
// All outputs are registered.
//
// Optional feature: define BTN_LONG_PRESS_EN to enable the per-channel hold counter and the
// btn_long pulse. When it is undefined, btn_long is tied low and no hold counter exists.
//
// Ports:
//   clk         - system clock
//   rst         - synchronous, active-high reset
//   btn_in      - raw asynchronous button levels, active-high (N_BTN bits)
//   btn_level   - debounced level per channel
//   btn_press   - one-cycle pulse on each accepted rising edge
//   btn_release - one-cycle pulse on each accepted falling edge
//   btn_long    - one-cycle pulse after LONG_CYCLES of continuous hold (0 if feature off)
module btn_debounce #(
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } state_e;

    localparam logic [31:0] CntLast = 32'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        state_e      state_q, state_d;
        logic [31:0] cnt_q, cnt_d;
        logic        level_q, level_d;
        logic        press_q, press_d;
        logic        rel_q, rel_d;
        logic        s;

        assign s = sync2_q[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (s) begin
                        state_d = StPressWait;
                        cnt_d   = '0;
                    end
                end
                StPressWait: begin
                    if (!s) begin
                        state_d = StIdle;
                    end else if (cnt_q == CntLast) begin
                        state_d = StHeld;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                StHeld: begin
                    if (!s) begin
                        state_d = StReleaseWait;
                        cnt_d   = '0;
                    end
                end
                StReleaseWait: begin
                    if (s) begin
                        state_d = StHeld;
                    end else if (cnt_q == CntLast) begin
                        state_d = StIdle;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = rel_q;

`ifdef BTN_LONG_PRESS_EN
        localparam logic [31:0] HoldLast = 32'(LONG_CYCLES - 1);
        localparam logic [31:0] HoldFire = 32'(LONG_CYCLES - 2);

        logic [31:0] hold_q, hold_d;
        logic        long_q, long_d;

        // Held at zero until the press is accepted; frozen across a release bounce so a
        // recovered hold keeps counting; saturates at HoldLast so the pulse never repeats.
        always_comb begin
            hold_d = hold_q;
            long_d = 1'b0;
            unique case (state_q)
                StIdle, StPressWait: hold_d = '0;
                StHeld: begin
                    if (hold_q != HoldLast) begin
                        hold_d = hold_q + 32'd1;
                        long_d = (hold_q == HoldFire);
                    end
                end
                StReleaseWait: hold_d = hold_q;
                default: hold_d = '0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                long_q <= long_d;
            end
        end

        assign btn_long[i] = long_q;
`else
        assign btn_long[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=16, N_BTN=2.
// Stimulus pushes expected output pulses (with their cycle numbers) into a scoreboard queue;
// a monitor pops and compares whenever the DUT shows any pulse.
module tb_btn_debounce;

    localparam int unsigned NB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_in = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;

    btn_debounce #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] lng;
        logic [NB-1:0] lvl;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int at, input logic [NB-1:0] p, input logic [NB-1:0] r,
                        input logic [NB-1:0] l, input logic [NB-1:0] v);
        ev_t e;
        e.at = at; e.press = p; e.rel = r; e.lng = l; e.lvl = v;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: any pulse on any channel must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && ((|btn_press) || (|btn_release) || (|btn_long))) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", int'({btn_press, btn_release, btn_long}), 0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("press", int'(btn_press), int'(e.press));
                chk("release", int'(btn_release), int'(e.rel));
                chk("long", int'(btn_long), int'(e.lng));
                chk("level_at_pulse", int'(btn_level), int'(e.lvl));
            end
        end
    end

    int c;

    initial begin
        // Reset state
        step(3);
        rst = 1'b0;
        chk("reset_level", int'(btn_level), 0);
        chk("reset_pulses", int'({btn_press, btn_release, btn_long}), 0);

        // Clean press on ch0, long hold, then release
        step(1);
        c = cyc;
        btn_in[0] = 1'b1;
        push(c + 7, 2'b01, 2'b00, 2'b00, 2'b01);
`ifdef BTN_LONG_PRESS_EN
        push(c + 22, 2'b00, 2'b00, 2'b01, 2'b01);
`endif
        wait_to(c + 8);
        chk("level_after_press", int'(btn_level), 1);
        wait_to(c + 37);
        btn_in[0] = 1'b0;
        push(c + 44, 2'b00, 2'b01, 2'b00, 2'b00);
        wait_to(c + 50);
        chk("level_after_release", int'(btn_level), 0);

        // Bounce on ch1: 1,0,1,0 one cycle each
        btn_in[1] = 1'b1; step(1);
        btn_in[1] = 1'b0; step(1);
        btn_in[1] = 1'b1; step(1);
        btn_in[1] = 1'b0; step(12);
        chk("bounce_level", int'(btn_level), 0);

        // Release glitch on ch1 while held
        c = cyc;
        btn_in[1] = 1'b1;
        push(c + 7, 2'b10, 2'b00, 2'b00, 2'b10);
        wait_to(c + 8);
        btn_in[1] = 1'b0;
        step(2);
        btn_in[1] = 1'b1;
        wait_to(c + 14);
        chk("glitch_level", int'(btn_level), 2);
        btn_in[1] = 1'b0;
        push(c + 21, 2'b00, 2'b10, 2'b00, 2'b00);
        wait_to(c + 26);

        // Simultaneous press/release on both channels
        c = cyc;
        btn_in = 2'b11;
        push(c + 7, 2'b11, 2'b00, 2'b00, 2'b11);
        wait_to(c + 10);
        btn_in = 2'b00;
        push(c + 17, 2'b00, 2'b11, 2'b00, 2'b00);
        wait_to(c + 22);
        chk("both_released", int'(btn_level), 0);

        // Reset mid-hold on ch0 with the button still held
        c = cyc;
        btn_in[0] = 1'b1;
        push(c + 7, 2'b01, 2'b00, 2'b00, 2'b01);
        wait_to(c + 10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_level", int'(btn_level), 0);
        chk("rst_pulses", int'({btn_press, btn_release, btn_long}), 0);
        push(c + 18, 2'b01, 2'b00, 2'b00, 2'b01);
        wait_to(c + 25);
        btn_in[0] = 1'b0;
        push(c + 32, 2'b00, 2'b01, 2'b00, 2'b00);
        wait_to(c + 38);

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
